// File: rtl/joypad_poller.sv
// -----------------------------------------------------------------------------
// joypad_poller
//   I2C master that periodically reads NUM_PADS joypad slaves located at
//   consecutive 7-bit addresses BASE_ADDR .. BASE_ADDR+NUM_PADS-1 and presents
//   the latched button bytes plus per-pad presence flags to the game core.
//   Bus outputs are open-drain style: 1 = release the line, 0 = pull low.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   polling allowed
//   scl_out  out  SCL drive (1 = release)
//   sda_in   in   sampled SDA pin level
//   sda_out  out  SDA drive (1 = release)
//   buttons  out  pad i at [i*8*BYTES +: 8*BYTES], first byte received is MSB
//   present  out  pad i acknowledged its address in the last poll
//   update   out  one-cycle pulse when a full round completes
//
// Build option
//   JOYPAD_DEBOUNCE_EN : buttons of a pad only change when two consecutive
//                        successful reads of that pad return the same data.
//
// States
//   S_IDLE  | bus released, poll counter running
//   S_START | START condition, 3 quarters
//   S_ADDR  | address byte {BASE_ADDR+pad, R}, MSB first
//   S_AACK  | slave address acknowledge bit
//   S_READ  | one data byte from the slave, MSB first
//   S_MACK  | master ACK (more bytes) or NACK (last byte)
//   S_STOP  | STOP condition, 3 quarters; commits results on completion
// -----------------------------------------------------------------------------
module joypad_poller #(
  parameter int         NUM_PADS    = 2,
  parameter logic [6:0] BASE_ADDR   = 7'h52,
  parameter int         BYTES       = 1,
  parameter int         CLK_DIV     = 5,
  parameter int         POLL_PERIOD = 20000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  output logic                        scl_out,
  input  logic                        sda_in,
  output logic                        sda_out,
  output logic [NUM_PADS*8*BYTES-1:0] buttons,
  output logic [NUM_PADS-1:0]         present,
  output logic                        update
);

  localparam int W  = 8 * BYTES;
  localparam int QW = $clog2(CLK_DIV) + 1;
  localparam int PW = $clog2(POLL_PERIOD) + 1;

  localparam logic [QW-1:0] Q_LOAD    = QW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(POLL_PERIOD - 1);
  localparam logic [2:0]    PAD_LAST  = 3'(NUM_PADS - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_READ,
    S_MACK,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [QW-1:0]          div_q, div_d;
  logic [1:0]             qtr_q, qtr_d;
  logic [2:0]             bit_q, bit_d;
  logic [1:0]             byte_q, byte_d;
  logic [2:0]             pad_q, pad_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic                   ack_q, ack_d;
  logic [W-1:0]           shift_q, shift_d;
  logic [NUM_PADS*W-1:0]  buttons_q, buttons_d;
  logic [NUM_PADS-1:0]    present_q, present_d;
  logic                   update_q, update_d;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [NUM_PADS*W-1:0]  raw_q, raw_d;
`endif

  logic       tick;
  logic       scl_bit;
  logic [7:0] addr_byte;
  logic       scl_drv, sda_drv;

  // Quarter-period divider: down-counter, one tick per terminal count.
  // Held at its load value in IDLE so the first quarter of a round is full.
  assign tick = (state_q != S_IDLE) && (div_q == '0);

  always_comb begin
    div_d = div_q;
    if (state_q == S_IDLE || div_q == '0) div_d = Q_LOAD;
    else                                  div_d = div_q - 1'b1;
  end

  // SCL is high in the middle two quarters of every data/ack bit.
  assign scl_bit   = qtr_q[0] ^ qtr_q[1];
  assign addr_byte = {BASE_ADDR + {4'd0, pad_q}, 1'b1};

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pad_d     = pad_q;
    ack_d     = ack_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    present_d = present_q;
    update_d  = 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
    raw_d     = raw_q;
`endif

    // Poll counter keeps running through a round so rounds start every
    // POLL_PERIOD cycles; it saturates if a round overruns the period.
    poll_d = poll_q;
    if (enable && poll_q != P_LAST) poll_d = poll_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (enable && poll_q == P_LAST) begin
          poll_d  = '0;
          pad_d   = '0;
          qtr_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (qtr_q == 2'd2) begin
            qtr_d   = '0;
            bit_d   = 3'd7;
            state_d = S_ADDR;
          end else begin
            qtr_d = qtr_q + 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd3) begin
            if (bit_q == 3'd0) state_d = S_AACK;
            else               bit_d   = bit_q - 1'b1;
          end
        end
      end

      S_AACK: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd2) ack_d = ~sda_in;
          if (qtr_q == 2'd3) begin
            byte_d  = '0;
            bit_d   = 3'd7;
            state_d = ack_q ? S_READ : S_STOP;
          end
        end
      end

      S_READ: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd2) shift_d = {shift_q[W-2:0], sda_in};
          if (qtr_q == 2'd3) begin
            if (bit_q == 3'd0) state_d = S_MACK;
            else               bit_d   = bit_q - 1'b1;
          end
        end
      end

      S_MACK: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd3) begin
            if (byte_q != BYTE_LAST) begin
              byte_d  = byte_q + 1'b1;
              bit_d   = 3'd7;
              state_d = S_READ;
            end else begin
              state_d = S_STOP;
            end
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (qtr_q == 2'd2) begin
            qtr_d = '0;
            for (int i = 0; i < NUM_PADS; i++) begin
              if (pad_q == 3'(i)) begin
                if (ack_q) begin
`ifdef JOYPAD_DEBOUNCE_EN
                  if (raw_q[i*W +: W] == shift_q) buttons_d[i*W +: W] = shift_q;
                  raw_d[i*W +: W] = shift_q;
`else
                  buttons_d[i*W +: W] = shift_q;
`endif
                  present_d[i] = 1'b1;
                end else begin
`ifdef JOYPAD_DEBOUNCE_EN
                  raw_d[i*W +: W] = '0;
`endif
                  buttons_d[i*W +: W] = '0;
                  present_d[i]        = 1'b0;
                end
              end
            end
            // Dropping enable mid-round abandons the remaining pads silently.
            if (enable && pad_q != PAD_LAST) begin
              pad_d   = pad_q + 1'b1;
              state_d = S_START;
            end else begin
              update_d = enable;
              state_d  = S_IDLE;
            end
          end else begin
            qtr_d = qtr_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Line drive is decoded from registered state only, so reset releases
  // both lines immediately.
  always_comb begin
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    case (state_q)
      S_START: begin
        scl_drv = (qtr_q != 2'd2);
        sda_drv = (qtr_q == 2'd0);
      end
      S_ADDR: begin
        scl_drv = scl_bit;
        sda_drv = addr_byte[bit_q];
      end
      S_AACK, S_READ: scl_drv = scl_bit;
      S_MACK: begin
        scl_drv = scl_bit;
        sda_drv = (byte_q == BYTE_LAST);
      end
      S_STOP: begin
        scl_drv = (qtr_q != 2'd0);
        sda_drv = (qtr_q == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= Q_LOAD;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      pad_q     <= '0;
      poll_q    <= '0;
      ack_q     <= 1'b0;
      shift_q   <= '0;
      buttons_q <= '0;
      present_q <= '0;
      update_q  <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
      raw_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      pad_q     <= pad_d;
      poll_q    <= poll_d;
      ack_q     <= ack_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      present_q <= present_d;
      update_q  <= update_d;
`ifdef JOYPAD_DEBOUNCE_EN
      raw_q     <= raw_d;
`endif
    end
  end

  assign scl_out = scl_drv;
  assign sda_out = sda_drv;
  assign buttons = buttons_q;
  assign present = present_q;
  assign update  = update_q;

endmodule

// File: tb/tb_joypad_poller.sv
`timescale 1ns/1ps
module tb_joypad_poller;
  localparam int         NP   = 2;
  localparam int         BY   = 2;
  localparam int         W    = 8 * BY;
  localparam int         CD   = 2;
  localparam int         PP   = 600;
  localparam logic [6:0] BASE = 7'h52;

  localparam int PH_IDLE = 0, PH_ADDR = 1, PH_AACK = 2, PH_DATA = 3, PH_MACK = 4, PH_IGN = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          scl_out, sda_out, sda_in;
  logic [NP*W-1:0] buttons;
  logic [NP-1:0] present;
  logic          update;
  logic          slv_drv = 1'b1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int prev_t0 = 0;
  bit have_prev = 0;

  assign sda_in = sda_out & slv_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  joypad_poller #(
    .NUM_PADS(NP), .BASE_ADDR(BASE), .BYTES(BY), .CLK_DIV(CD), .POLL_PERIOD(PP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .scl_out(scl_out), .sda_in(sda_in), .sda_out(sda_out),
    .buttons(buttons), .present(present), .update(update)
  );

  // slave configuration and expected-result model
  logic         cfg_ack  [NP];
  logic [W-1:0] cfg_data [NP];
  logic [W-1:0] exp_btn  [NP];
  logic         exp_pres [NP];
  logic [W-1:0] raw_m    [NP];

  function automatic void model_pad(input int p);
    if (cfg_ack[p]) begin
`ifdef JOYPAD_DEBOUNCE_EN
      if (cfg_data[p] == raw_m[p]) exp_btn[p] = cfg_data[p];
      raw_m[p] = cfg_data[p];
`else
      exp_btn[p] = cfg_data[p];
`endif
      exp_pres[p] = 1'b1;
    end else begin
      exp_btn[p]  = '0;
      raw_m[p]    = '0;
      exp_pres[p] = 1'b0;
    end
  endfunction

  // bus monitor + joypad slave, sampled on the falling clock edge
  int         n_start = 0, n_stop = 0, n_upd = 0, t_start = 0;
  int         sphase = PH_IDLE, scnt = 0, cur_pad = -1, bidx = 0;
  logic [7:0] sbyte = '0, cur_byte = '0;
  logic       mack_bit = 1'b1;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] addr_log [$];
  logic       mack_log [$];

  always @(negedge clk) begin
    logic s, d;
    s = scl_out;
    d = sda_in;
    if (!rst_n) begin
      sphase  = PH_IDLE;
      slv_drv = 1'b1;
    end else begin
      if (update === 1'b1) n_upd++;
      if (scl_p && s && sda_p && !d) begin
        if (n_start == 0) t_start = cyc;
        n_start++;
        sphase  = PH_ADDR;
        scnt    = 0;
        slv_drv = 1'b1;
      end else if (scl_p && s && !sda_p && d) begin
        n_stop++;
        sphase  = PH_IDLE;
        slv_drv = 1'b1;
      end else if (!scl_p && s) begin
        case (sphase)
          PH_ADDR: begin
            sbyte = {sbyte[6:0], d};
            scnt++;
            if (scnt == 8) addr_log.push_back(sbyte);
          end
          PH_DATA: scnt++;
          PH_MACK: begin
            mack_bit = d;
            mack_log.push_back(d);
          end
          default: ;
        endcase
      end else if (scl_p && !s) begin
        case (sphase)
          PH_ADDR: if (scnt == 8) begin
            cur_pad = -1;
            for (int p = 0; p < NP; p++)
              if (sbyte == {7'(BASE + 7'(p)), 1'b1}) cur_pad = p;
            if (cur_pad >= 0 && cfg_ack[cur_pad]) begin
              sphase  = PH_AACK;
              slv_drv = 1'b0;
            end else begin
              sphase = PH_IGN;
            end
          end
          PH_AACK: begin
            sphase   = PH_DATA;
            scnt     = 0;
            bidx     = 0;
            cur_byte = cfg_data[cur_pad][W-1 -: 8];
            slv_drv  = cur_byte[7];
          end
          PH_DATA: begin
            if (scnt == 8) begin
              sphase  = PH_MACK;
              slv_drv = 1'b1;
            end else begin
              slv_drv = cur_byte[7 - scnt];
            end
          end
          PH_MACK: begin
            if (mack_bit == 1'b0 && bidx < BY - 1) begin
              bidx++;
              cur_byte = cfg_data[cur_pad][W-1-8*bidx -: 8];
              sphase   = PH_DATA;
              scnt     = 0;
              slv_drv  = cur_byte[7];
            end else begin
              sphase = PH_IGN;
            end
          end
          default: ;
        endcase
      end
    end
    scl_p = s;
    sda_p = d;
  end

  task automatic clear_mon();
    n_start = 0;
    n_stop  = 0;
    n_upd   = 0;
    addr_log.delete();
    mack_log.delete();
  endtask

  // Waits for the end of one round and checks it against the model.
  task automatic run_round(input string tag);
    bit            got;
    logic          em [$];
    logic [NP-1:0] ep;
    got = 0;
    for (int k = 0; k < 1500 && !got; k++) begin
      @(negedge clk);
      if (update === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s update_timeout: no update pulse within 1500 cycles", tag);
      return;
    end
    @(negedge clk);
    n_checks++;
    if (update !== 1'b0) begin
      n_fail++;
      $display("FAIL %s update_width: update=%b required 0 one cycle later", tag, update);
    end
    for (int p = 0; p < NP; p++) model_pad(p);
    n_checks++;
    if (n_start != NP) begin
      n_fail++;
      $display("FAIL %s start_count: got %0d required %0d", tag, n_start, NP);
    end
    n_checks++;
    if (n_stop != NP) begin
      n_fail++;
      $display("FAIL %s stop_count: got %0d required %0d", tag, n_stop, NP);
    end
    n_checks++;
    if (n_upd != 1) begin
      n_fail++;
      $display("FAIL %s update_count: got %0d required 1", tag, n_upd);
    end
    n_checks++;
    if (addr_log.size() != NP) begin
      n_fail++;
      $display("FAIL %s addr_count: got %0d required %0d", tag, addr_log.size(), NP);
    end else begin
      for (int p = 0; p < NP; p++) begin
        n_checks++;
        if (addr_log[p] !== {7'(BASE + 7'(p)), 1'b1}) begin
          n_fail++;
          $display("FAIL %s addr_byte%0d: got %h required %h", tag, p, addr_log[p], {7'(BASE + 7'(p)), 1'b1});
        end
      end
    end
    for (int p = 0; p < NP; p++)
      if (cfg_ack[p]) begin
        for (int b = 0; b < BY - 1; b++) em.push_back(1'b0);
        em.push_back(1'b1);
      end
    n_checks++;
    if (mack_log.size() != em.size()) begin
      n_fail++;
      $display("FAIL %s mack_count: got %0d required %0d", tag, mack_log.size(), em.size());
    end else begin
      for (int i = 0; i < em.size(); i++) begin
        n_checks++;
        if (mack_log[i] !== em[i]) begin
          n_fail++;
          $display("FAIL %s mack_bit%0d: got %b required %b", tag, i, mack_log[i], em[i]);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      ep[p] = exp_pres[p];
      n_checks++;
      if (buttons[p*W +: W] !== exp_btn[p]) begin
        n_fail++;
        $display("FAIL %s buttons_pad%0d: got %h required %h", tag, p, buttons[p*W +: W], exp_btn[p]);
      end
    end
    n_checks++;
    if (present !== ep) begin
      n_fail++;
      $display("FAIL %s present: got %b required %b", tag, present, ep);
    end
    if (have_prev) begin
      n_checks++;
      if (t_start - prev_t0 != PP) begin
        n_fail++;
        $display("FAIL %s round_spacing: got %0d required %0d", tag, t_start - prev_t0, PP);
      end
    end
    prev_t0   = t_start;
    have_prev = 1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (scl_out !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b required 1", scl_out); end
    n_checks++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b required 1", sda_out); end
    n_checks++; if (buttons !== '0) begin n_fail++; $display("FAIL reset_buttons: got %h required 0", buttons); end
    n_checks++; if (present !== '0) begin n_fail++; $display("FAIL reset_present: got %b required 0", present); end
    n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b required 0", update); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_round();
    cfg_ack[0]  = 1'b1; cfg_data[0] = 16'h1234;
    cfg_ack[1]  = 1'b0; cfg_data[1] = 16'h5555;
    clear_mon();
    enable = 1'b1;
    run_round("first");
    n_checks++;
    if (addr_log[1] !== 8'hA7) begin
      n_fail++;
      $display("FAIL first_pad1_addr: got %h required a7", addr_log[1]);
    end
`ifndef JOYPAD_DEBOUNCE_EN
    n_checks++;
    if (buttons !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL first_buttons: got %h required 00001234", buttons);
    end
    n_checks++;
    if (present !== 2'b01) begin
      n_fail++;
      $display("FAIL first_present: got %b required 01", present);
    end
`endif
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NP; p++) begin
        cfg_ack[p] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) != 0) cfg_data[p] = W'($urandom);
      end
      clear_mon();
      run_round($sformatf("rand%0d", r));
    end
  endtask

`ifdef JOYPAD_DEBOUNCE_EN
  task automatic test_debounce();
    logic [W-1:0] seq [4];
    logic [W-1:0] want [4];
    seq  = '{16'h0000, 16'h000F, 16'h00F0, 16'h00F0};
    want = '{16'h0000, 16'h0000, 16'h0000, 16'h00F0};
    for (int r = 0; r < 4; r++) begin
      cfg_ack[0]  = (r != 0);
      cfg_data[0] = seq[r];
      clear_mon();
      run_round($sformatf("debounce%0d", r));
      n_checks++;
      if (buttons[W-1:0] !== want[r]) begin
        n_fail++;
        $display("FAIL debounce_step%0d: got %h required %h", r, buttons[W-1:0], want[r]);
      end
    end
  endtask
`endif

  task automatic test_enable_drop();
    bit            got;
    logic [NP-1:0] ep;
    got = 0;
    cfg_ack[0] = 1'b1; cfg_data[0] = W'($urandom);
    cfg_ack[1] = 1'b1; cfg_data[1] = W'($urandom);
    clear_mon();
    for (int k = 0; k < 1500 && !got; k++) begin
      @(negedge clk);
      if (sphase == PH_DATA && cur_pad == 0) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL drop_wait: pad 0 read never observed within 1500 cycles");
    end
    enable = 1'b0;
    repeat (PP) @(negedge clk);
    model_pad(0);
    for (int p = 0; p < NP; p++) ep[p] = exp_pres[p];
    n_checks++; if (n_upd != 0)   begin n_fail++; $display("FAIL drop_update: got %0d pulses required 0", n_upd); end
    n_checks++; if (n_start != 1) begin n_fail++; $display("FAIL drop_starts: got %0d required 1", n_start); end
    n_checks++; if (n_stop != 1)  begin n_fail++; $display("FAIL drop_stops: got %0d required 1", n_stop); end
    n_checks++; if (scl_out !== 1'b1) begin n_fail++; $display("FAIL drop_scl: got %b required 1", scl_out); end
    n_checks++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL drop_sda: got %b required 1", sda_out); end
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (buttons[p*W +: W] !== exp_btn[p]) begin
        n_fail++;
        $display("FAIL drop_buttons_pad%0d: got %h required %h", p, buttons[p*W +: W], exp_btn[p]);
      end
    end
    n_checks++;
    if (present !== ep) begin
      n_fail++;
      $display("FAIL drop_present: got %b required %b", present, ep);
    end
    have_prev = 0;
  endtask

  task automatic test_reset_mid_addr();
    bit got;
    got = 0;
    clear_mon();
    enable = 1'b1;
    for (int k = 0; k < 1500 && !got; k++) begin
      @(negedge clk);
      if (sphase == PH_ADDR && scnt == 5 && scl_out === 1'b0) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL mid_reset_wait: address bit 3 never observed within 1500 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (scl_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset_scl: got %b required 1", scl_out); end
    n_checks++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset_sda: got %b required 1", sda_out); end
    n_checks++; if (buttons !== '0) begin n_fail++; $display("FAIL mid_reset_buttons: got %h required 0", buttons); end
    n_checks++; if (present !== '0) begin n_fail++; $display("FAIL mid_reset_present: got %b required 0", present); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      cfg_ack[p]  = 1'b0;
      cfg_data[p] = '0;
      exp_btn[p]  = '0;
      exp_pres[p] = 1'b0;
      raw_m[p]    = '0;
    end
    test_reset();
    test_first_round();
    test_random_rounds();
`ifdef JOYPAD_DEBOUNCE_EN
    test_debounce();
`endif
    test_enable_drop();
    test_reset_mid_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
